// File: rtl/ex_mem.sv
// ex_mem: execute -> memory-access pipeline register of the five-stage MIPS core.
// Latches GPR write, HI/LO write, load/store op, address and store data, and
// carries the multiply-accumulate partial product / cycle counter back to
// execute across a stall.
// Optional feature macro: EX_MEM_MACC_EN (define to keep the hilo_temp/cnt
// feedback registers; undefined ties hilo_temp_o and cnt_o to zero).
module ex_mem (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic [5:0]  stall,        // [3] execute stalled, [4] memory stalled
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_opv2,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic        mem_we,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_opv2,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  // Capture whenever execute advances; the illegal stall[3]=0/stall[4]=1
  // combination therefore also captures. Bubble when only execute stalls.
  logic do_capture;
  logic do_bubble;
  assign do_capture = ~stall[3];
  assign do_bubble  = stall[3] & ~stall[4];

  logic        mem_we_q,       mem_we_d;
  logic [4:0]  mem_waddr_q,    mem_waddr_d;
  logic [31:0] mem_wdata_q,    mem_wdata_d;
  logic        mem_whilo_q,    mem_whilo_d;
  logic [31:0] mem_hi_q,       mem_hi_d;
  logic [31:0] mem_lo_q,       mem_lo_d;
  logic [7:0]  mem_aluop_q,    mem_aluop_d;
  logic [31:0] mem_mem_addr_q, mem_mem_addr_d;
  logic [31:0] mem_opv2_q,     mem_opv2_d;

  // Next-state for the forward pipeline fields: hold, bubble (all zero = NOP) or capture.
  always_comb begin
    mem_we_d       = mem_we_q;
    mem_waddr_d    = mem_waddr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_whilo_d    = mem_whilo_q;
    mem_hi_d       = mem_hi_q;
    mem_lo_d       = mem_lo_q;
    mem_aluop_d    = mem_aluop_q;
    mem_mem_addr_d = mem_mem_addr_q;
    mem_opv2_d     = mem_opv2_q;
    if (do_capture) begin
      mem_we_d       = ex_we;
      mem_waddr_d    = ex_waddr;
      mem_wdata_d    = ex_wdata;
      mem_whilo_d    = ex_whilo;
      mem_hi_d       = ex_hi;
      mem_lo_d       = ex_lo;
      mem_aluop_d    = ex_aluop;
      mem_mem_addr_d = ex_mem_addr;
      mem_opv2_d     = ex_opv2;
    end else if (do_bubble) begin
      mem_we_d       = 1'b0;
      mem_waddr_d    = 5'd0;
      mem_wdata_d    = 32'd0;
      mem_whilo_d    = 1'b0;
      mem_hi_d       = 32'd0;
      mem_lo_d       = 32'd0;
      mem_aluop_d    = 8'd0;
      mem_mem_addr_d = 32'd0;
      mem_opv2_d     = 32'd0;
    end
  end

  // Forward pipeline flops, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= 5'd0;
      mem_wdata_q    <= 32'd0;
      mem_whilo_q    <= 1'b0;
      mem_hi_q       <= 32'd0;
      mem_lo_q       <= 32'd0;
      mem_aluop_q    <= 8'd0;
      mem_mem_addr_q <= 32'd0;
      mem_opv2_q     <= 32'd0;
    end else begin
      mem_we_q       <= mem_we_d;
      mem_waddr_q    <= mem_waddr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_whilo_q    <= mem_whilo_d;
      mem_hi_q       <= mem_hi_d;
      mem_lo_q       <= mem_lo_d;
      mem_aluop_q    <= mem_aluop_d;
      mem_mem_addr_q <= mem_mem_addr_d;
      mem_opv2_q     <= mem_opv2_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_whilo    = mem_whilo_q;
  assign mem_hi       = mem_hi_q;
  assign mem_lo       = mem_lo_q;
  assign mem_aluop    = mem_aluop_q;
  assign mem_mem_addr = mem_mem_addr_q;
  assign mem_opv2     = mem_opv2_q;

`ifdef EX_MEM_MACC_EN
  logic [63:0] hilo_temp_q, hilo_temp_d;
  logic [1:0]  cnt_q,       cnt_d;

  // Accumulate state: kept across a bubble so the second madd/msub cycle
  // sees the first cycle's result; cleared once the instruction leaves execute.
  always_comb begin
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
    if (do_capture) begin
      hilo_temp_d = 64'd0;
      cnt_d       = 2'd0;
    end else if (do_bubble) begin
      hilo_temp_d = hilo_temp_i;
      cnt_d       = cnt_i;
    end
  end

  // Accumulate feedback flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_temp_q <= 64'd0;
      cnt_q       <= 2'd0;
    end else begin
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
`else
  // Core without multiply-accumulate: feedback inputs are unused.
  logic unused_macc;
  assign unused_macc = ^{hilo_temp_i, cnt_i};
  assign hilo_temp_o = 64'd0;
  assign cnt_o       = 2'd0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem. Honors EX_MEM_MACC_EN for the expected
// hilo_temp_o / cnt_o values.
`timescale 1ns/1ps
module tb_ex_mem;

`ifdef EX_MEM_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif
  localparam logic [7:0] SW_OP = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        ex_we, ex_whilo;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_opv2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic        mem_we, mem_whilo;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_opv2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_opv2(ex_opv2),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_opv2(mem_opv2),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 6'd0;
    ex_we = 0; ex_whilo = 0; ex_waddr = 0; ex_wdata = 0; ex_hi = 0; ex_lo = 0;
    ex_aluop = 0; ex_mem_addr = 0; ex_opv2 = 0; hilo_temp_i = 0; cnt_i = 0;
    #1;
    check("reset_we", {63'd0, mem_we}, 64'd0);
    check("reset_aluop", {56'd0, mem_aluop}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Capture
    stall = 6'b000000; ex_we = 1; ex_waddr = 5'd3; ex_wdata = 32'h1234_5678;
    ex_whilo = 1; ex_hi = 32'hAAAA_0000; ex_lo = 32'h0000_BBBB;
    hilo_temp_i = 64'h55; cnt_i = 2'd2;
    step();
    check("cap_we", {63'd0, mem_we}, 64'd1);
    check("cap_waddr", {59'd0, mem_waddr}, 64'd3);
    check("cap_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
    check("cap_whilo", {63'd0, mem_whilo}, 64'd1);
    check("cap_hi", {32'd0, mem_hi}, 64'hAAAA_0000);
    check("cap_lo", {32'd0, mem_lo}, 64'h0000_BBBB);
    check("cap_hilo_temp", hilo_temp_o, 64'd0);
    check("cap_cnt", {62'd0, cnt_o}, 64'd0);

    // Hold for 3 cycles while inputs change
    stall = 6'b011111; ex_waddr = 5'd7; ex_wdata = 32'hCAFE_F00D; ex_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_wdata", i), {32'd0, mem_wdata}, 64'h1234_5678);
      check($sformatf("hold%0d_waddr", i), {59'd0, mem_waddr}, 64'd3);
      check($sformatf("hold%0d_we", i), {63'd0, mem_we}, 64'd1);
    end
    stall = 6'b000000;
    step();
    check("rel_wdata", {32'd0, mem_wdata}, 64'hCAFE_F00D);
    check("rel_waddr", {59'd0, mem_waddr}, 64'd7);
    check("rel_we", {63'd0, mem_we}, 64'd0);

    // Bubble
    stall = 6'b001111; ex_we = 1; ex_wdata = 32'hFFFF_FFFF; ex_aluop = 8'h18;
    ex_whilo = 1; hilo_temp_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
    step();
    check("bub_we", {63'd0, mem_we}, 64'd0);
    check("bub_wdata", {32'd0, mem_wdata}, 64'd0);
    check("bub_aluop", {56'd0, mem_aluop}, 64'd0);
    check("bub_whilo", {63'd0, mem_whilo}, 64'd0);
    check("bub_hilo_temp", hilo_temp_o, MACC ? 64'h0000_0001_0000_0002 : 64'd0);
    check("bub_cnt", {62'd0, cnt_o}, MACC ? 64'd1 : 64'd0);

    // Hold keeps the accumulate state too
    stall = 6'b011111; hilo_temp_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'b11;
    step();
    check("holdacc_hilo_temp", hilo_temp_o, MACC ? 64'h0000_0001_0000_0002 : 64'd0);
    check("holdacc_cnt", {62'd0, cnt_o}, MACC ? 64'd1 : 64'd0);
    check("holdacc_we", {63'd0, mem_we}, 64'd0);

    // Store pass-through; capture clears accumulate state
    stall = 6'b000000; ex_aluop = SW_OP; ex_mem_addr = 32'h0000_0010; ex_opv2 = 32'hDEAD_BEEF;
    step();
    check("sw_aluop", {56'd0, mem_aluop}, {56'd0, SW_OP});
    check("sw_addr", {32'd0, mem_mem_addr}, 64'h10);
    check("sw_opv2", {32'd0, mem_opv2}, 64'hDEAD_BEEF);
    check("sw_hilo_temp", hilo_temp_o, 64'd0);
    check("sw_cnt", {62'd0, cnt_o}, 64'd0);

    // Illegal stall[3]=0, stall[4]=1 behaves as capture
    stall = 6'b010000; ex_wdata = 32'h0BAD_F00D; ex_waddr = 5'd31; hilo_temp_i = 64'h77; cnt_i = 2'd3;
    step();
    check("ill_wdata", {32'd0, mem_wdata}, 64'h0BAD_F00D);
    check("ill_waddr", {59'd0, mem_waddr}, 64'd31);
    check("ill_cnt", {62'd0, cnt_o}, 64'd0);

    // Bubble again to load accumulate state, then asynchronous reset mid-cycle
    stall = 6'b001111; hilo_temp_i = 64'h1234; cnt_i = 2'd2;
    step();
    stall = 6'b000000; ex_wdata = 32'h5555_AAAA;
    step();
    check("pre_rst_wdata", {32'd0, mem_wdata}, 64'h5555_AAAA);
    #1 rst = 1'b0;
    #1;
    check("arst_we", {63'd0, mem_we}, 64'd0);
    check("arst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("arst_waddr", {59'd0, mem_waddr}, 64'd0);
    check("arst_aluop", {56'd0, mem_aluop}, 64'd0);
    check("arst_addr", {32'd0, mem_mem_addr}, 64'd0);
    check("arst_opv2", {32'd0, mem_opv2}, 64'd0);
    check("arst_hilo", {32'd0, mem_hi ^ mem_lo}, 64'd0);
    check("arst_hilo_temp", hilo_temp_o, 64'd0);
    step();
    check("arst_held_wdata", {32'd0, mem_wdata}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It latches every execute-stage result needed by memory access and write-back: GPR write, HI/LO write, load/store operation, address and store data. It obeys the stall vector from the pipeline controller and inserts a bubble when execute stalls but memory access does not. It also carries the two-cycle multiply-accumulate state (partial product and cycle counter) back to the execute stage across a stall.

## Interface
Parameters: none. Widths come from `const.v`: `RegBus` 32, `RegAddrBus` 5, `AluOpBus` 8, `DoubleRegBus` 64.

Ports, clock and reset first:
- clk  input  1  single core clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  6  controller stall vector; bit 3 = execute stalled, bit 4 = memory access stalled
- ex_we  input  1  GPR write enable from execute
- ex_waddr  input  RegAddrBus  GPR destination
- ex_wdata  input  RegBus  GPR write data
- ex_whilo  input  1  HI/LO write enable
- ex_hi, ex_lo  input  RegBus  HI/LO write values
- ex_aluop  input  AluOpBus  operation code; memory access decodes load/store from it
- ex_mem_addr  input  RegBus  effective load/store address
- ex_opv2  input  RegBus  store data
- hilo_temp_i  input  DoubleRegBus  partial product from execute (madd/msub first cycle)
- cnt_i  input  2  accumulate cycle counter from execute
- mem_we, mem_waddr, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_opv2  output  same widths as the matching ex_* inputs  registered copies to memory access
- hilo_temp_o  output  DoubleRegBus  registered partial product, fed back to execute
- cnt_o  output  2  registered counter, fed back to execute

## Operation
- Reset (rst=0, asynchronous): every output is 0. A zero `mem_aluop` is the NOP code.
- The register takes exactly one action per clk edge. The actions, highest priority first:
  - **Hold** (stall[3]=1, stall[4]=1): all outputs keep their values, including hilo_temp_o and cnt_o.
  - **Bubble** (stall[3]=1, stall[4]=0): all mem_* outputs become 0, which is a NOP. hilo_temp_o and cnt_o capture hilo_temp_i and cnt_i, so the first multiply-accumulate cycle survives the stall that execute requests for its second cycle.
  - **Capture** (stall[3]=0): all mem_* outputs capture the matching ex_* inputs. hilo_temp_o becomes 0 and cnt_o becomes 0, which clears the accumulate state once the instruction leaves execute.
- stall[3]=0 with stall[4]=1 is illegal from the controller. The block treats it as Capture.
- No arithmetic is done here. Values pass through bit-exact.

## Timing
- Latency: one cycle from an ex_* input to the matching mem_* output on Capture.
- Feedback path: hilo_temp_i and cnt_i, captured on a Bubble, are visible on hilo_temp_o and cnt_o in the next cycle. Execute's second accumulate cycle reads them there.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. The first Capture after rst rises is the first clk edge with rst=1 and stall[3]=0.
- Outputs are driven only by flops. There is no combinational path from inputs to outputs.

## Configuration
- `EX_MEM_MACC_EN` defined: the hilo_temp and cnt feedback registers exist and behave as described under Operation.
- `EX_MEM_MACC_EN` undefined: hilo_temp_o and cnt_o are tied to 0 and their registers are removed. hilo_temp_i and cnt_i are ignored. The remaining behaviour is unchanged. Use this in cores without madd/maddu/msub/msubu.

## Test plan
- Reset: drive rst=0 mid-cycle with nonzero inputs -> all outputs read 0 at once, before the next clk edge.
- Capture: stall=6'b000000, ex_we=1, ex_waddr=5'd3, ex_wdata=32'h1234_5678 -> next cycle mem_we=1, mem_waddr=3, mem_wdata=32'h1234_5678, hilo_temp_o=0, cnt_o=0.
- Bubble: stall=6'b001111, ex_we=1, ex_wdata=32'hFFFF_FFFF, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=2'b01 -> next cycle mem_we=0, mem_wdata=0, mem_aluop=0, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1.
- Hold: after the Capture case, apply stall=6'b011111 for 3 cycles while inputs change -> outputs stay at the captured values; release with stall=0 -> the new inputs appear the following cycle.
- Store pass-through: ex_aluop = SW opcode, ex_mem_addr=32'h0000_0010, ex_opv2=32'hDEAD_BEEF -> next cycle mem_aluop, mem_mem_addr and mem_opv2 match exactly.
- Macro off (`EX_MEM_MACC_EN` undefined): repeat the Bubble case -> hilo_temp_o=0, cnt_o=0; mem_* outputs as in the Bubble case.
